// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Widths, the x0 address and the INIT/RUN state encoding.
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int WCNT_W = 4;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // One write-port transaction as seen by the register file.
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] a3;
        logic [XLEN-1:0]   wd3;
    } rf_wr_t;

    // Idle port: nothing enabled, address and data parked at zero.
    function automatic rf_wr_t rf_idle();
        rf_wr_t w;
        w.we  = 1'b0;
        w.a3  = REG_ZERO;
        w.wd3 = '0;
        return w;
    endfunction

    // A granted write; x0 is hardwired so its enable is suppressed.
    function automatic rf_wr_t rf_grant(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   data
    );
        rf_wr_t w;
        w.we  = (addr != REG_ZERO);
        w.a3  = addr;
        w.wd3 = data;
        return w;
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_clear_seq.sv
// Post-reset clear sequencer for the register file.
// Walks idx through 0..NREG-1 and flags the last write.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    output logic [REG_AW-1:0] idx_o,
    output logic              done_o
);

    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);

    logic [REG_AW-1:0] idx_q;
    logic [REG_AW-1:0] idx_d;

    // Advance the pointer only while the clear is running.
    always_comb begin
        idx_d = idx_q;
        if (active_i) begin
            idx_d = idx_q + REG_AW'(1);
        end
    end

    // Pointer register; wraps back to 0 after the last entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign done_o = active_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single write-port owner for the 32x32 RV32I register file.
// Clears after reset, then arbitrates writeback vs debug writes.
module regfile_wport_arbiter
    import rf_pkg::*;
#(
    parameter int INIT_CLEAR = 1,
    parameter int MAX_WAIT   = 4,
    parameter int NREG       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              dbg_req,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_data,
    output logic              dbg_ack,
    output logic              wb_stall,
    output logic              init_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd3
);

    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);
    localparam logic [0:0] ST_RESET =
        (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
    localparam logic INIT_FLAG = (INIT_CLEAR != 0);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [WCNT_W-1:0] wait_q;
    logic [WCNT_W-1:0] wait_d;

    logic              in_init;
    logic              in_run;
    logic [REG_AW-1:0] clr_idx;
    logic              clr_done;

    logic              starve;
    logic              grant_dbg;
    logic              grant_wb;
    rf_wr_t            port;

    assign in_init = (state_q == ST_INIT);
    assign in_run  = (state_q == ST_RUN);

    rf_clear_seq #(
        .NREG (NREG)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .active_i (in_init),
        .idx_o    (clr_idx),
        .done_o   (clr_done)
    );

    // Grant decision: starvation override, then writeback, then debug.
    always_comb begin
        starve    = dbg_req && wb_we && (wait_q == WAIT_LIM);
        grant_dbg = 1'b0;
        grant_wb  = 1'b0;
        if (in_run) begin
            if (starve) begin
                grant_dbg = 1'b1;
            end else if (wb_we) begin
                grant_wb = 1'b1;
            end else if (dbg_req) begin
                grant_dbg = 1'b1;
            end
        end
    end

    // Port drive and handshake outputs; reset overrides everything.
    always_comb begin
        port      = rf_idle();
        dbg_ack   = 1'b0;
        wb_stall  = 1'b0;
        init_busy = 1'b0;
        if (!rst) begin
            wb_stall  = 1'b1;
            init_busy = INIT_FLAG;
        end else if (in_init) begin
            port.we   = 1'b1;
            port.a3   = clr_idx;
            wb_stall  = 1'b1;
            init_busy = 1'b1;
        end else if (grant_dbg) begin
            port     = rf_grant(dbg_addr, dbg_data);
            dbg_ack  = 1'b1;
            wb_stall = wb_we;
        end else if (grant_wb) begin
            port = rf_grant(wb_addr, wb_data);
        end
    end

    assign rf_we  = port.we;
    assign rf_a3  = port.a3;
    assign rf_wd3 = port.wd3;

    // Next state and debug wait counter.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (in_init) begin
            wait_d = '0;
            if (clr_done) begin
                state_d = ST_RUN;
            end
        end else if (!dbg_req || grant_dbg) begin
            wait_d = '0;
        end else if (wait_q != WAIT_LIM) begin
            wait_d = wait_q + WCNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RESET;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter.
// Cycle model of the port rules plus directed literal checks.
module tb_regfile_wport_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        dbg_req = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data = '0;
    logic        dbg_ack;
    logic        wb_stall;
    logic        init_busy;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    int n_chk = 0;
    int n_fail = 0;

    logic        preload = 1'b0;
    logic [31:0] rf_mem [32];

    regfile_wport_arbiter #(
        .INIT_CLEAR (1),
        .MAX_WAIT   (MAXW),
        .NREG       (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_ack   (dbg_ack),
        .wb_stall  (wb_stall),
        .init_busy (init_busy),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT write port.
    always @(posedge clk) begin
        if (preload) rf_mem[2] <= 32'd3;
        if (rf_we) rf_mem[rf_a3] <= rf_wd3;
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: clearing count and debug denial count.
    bit m_clearing = 1'b1;
    int m_cleared = 0;
    int m_denied = 0;

    always @(negedge clk) begin
        logic        e_we, e_ack, e_stall, e_busy, wd_ok;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        bit dbg_wins, wb_wins;
        e_we = 0; e_ack = 0; e_stall = 0; e_busy = 0;
        e_a3 = 0; e_wd = 0; wd_ok = 1;
        if (!rst) begin
            e_stall = 1; e_busy = 1;
            m_clearing = 1; m_cleared = 0; m_denied = 0;
        end else if (m_clearing) begin
            e_we = 1; e_a3 = 5'(m_cleared);
            e_stall = 1; e_busy = 1;
            m_cleared++;
            if (m_cleared == 32) m_clearing = 0;
            m_denied = 0;
        end else begin
            dbg_wins = dbg_req && (!wb_we || m_denied >= MAXW);
            wb_wins = wb_we && !dbg_wins;
            if (dbg_wins) begin
                e_a3 = dbg_addr; e_wd = dbg_data; e_ack = 1;
            end else if (wb_wins) begin
                e_a3 = wb_addr; e_wd = wb_data;
            end
            if (dbg_wins || wb_wins) begin
                e_we = (e_a3 != 0);
                wd_ok = e_we;
            end
            e_stall = wb_we && !wb_wins;
            if (dbg_req && !dbg_wins)
                m_denied = (m_denied < MAXW) ? m_denied + 1 : MAXW;
            else
                m_denied = 0;
        end
        check("m_rf_we", 32'(rf_we), 32'(e_we));
        check("m_rf_a3", 32'(rf_a3), 32'(e_a3));
        if (wd_ok) check("m_rf_wd3", rf_wd3, e_wd);
        check("m_dbg_ack", 32'(dbg_ack), 32'(e_ack));
        check("m_wb_stall", 32'(wb_stall), 32'(e_stall));
        check("m_init_busy", 32'(init_busy), 32'(e_busy));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int ack_cyc;
        int wb_grants;
        bit got;
        // Reset with a preloaded x2
        preload = 1'b1;
        next_cycle();
        preload = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_stall", 32'(wb_stall), 32'd1);
        check("rst_we", 32'(rf_we), 32'd0);
        check("pre_x2", rf_mem[2], 32'd3);
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("clr_we", 32'(rf_we), 32'd1);
            check("clr_a3", 32'(rf_a3), 32'(i));
            check("clr_wd", rf_wd3, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("run_busy", 32'(init_busy), 32'd0);
        check("x2_clear", rf_mem[2], 32'd0);
        check("x31_clear", rf_mem[31], 32'd0);
        next_cycle();

        // Plain writeback
        wb_we = 1; wb_addr = 9; wb_data = 32'h20;
        @(negedge clk);
        check("wb_we", 32'(rf_we), 32'd1);
        check("wb_a3", 32'(rf_a3), 32'd9);
        check("wb_wd", rf_wd3, 32'h20);
        check("wb_stall0", 32'(wb_stall), 32'd0);
        next_cycle();
        wb_we = 0;
        check("x9", rf_mem[9], 32'h20);

        // Debug write with idle writeback
        dbg_req = 1; dbg_addr = 6; dbg_data = 32'h40;
        @(negedge clk);
        check("dbg_ack", 32'(dbg_ack), 32'd1);
        check("dbg_a3", 32'(rf_a3), 32'd6);
        next_cycle();
        dbg_req = 0;
        check("x6", rf_mem[6], 32'h40);

        // Starvation: debug held against continuous writeback
        k = 0; ack_cyc = -1; wb_grants = 0; got = 0;
        dbg_req = 1; dbg_addr = 7; dbg_data = 32'h77;
        wb_we = 1; wb_addr = 10; wb_data = 32'h100;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (dbg_ack) begin
                got = 1; ack_cyc = c;
                check("stv_stall", 32'(wb_stall), 32'd1);
                check("stv_a3", 32'(rf_a3), 32'd7);
            end else if (!wb_stall && rf_we) begin
                wb_grants++;
            end
            if (!wb_stall) k++;
            next_cycle();
            if (got) dbg_req = 0;
            wb_addr = 5'(10 + k);
            wb_data = 32'h100 + 32'(k);
        end
        check("stv_ack_cycle", 32'(ack_cyc), 32'd4);
        check("stv_wb_grants", 32'(wb_grants), 32'd4);
        @(negedge clk);
        check("held_stall", 32'(wb_stall), 32'd0);
        check("held_a3", 32'(rf_a3), 32'd14);
        check("held_wd", rf_wd3, 32'h104);
        next_cycle();
        wb_we = 0;
        check("x7", rf_mem[7], 32'h77);
        check("x10", rf_mem[10], 32'h100);
        check("x14", rf_mem[14], 32'h104);

        // x0 writes are consumed but dropped
        wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("x0_wb_we", 32'(rf_we), 32'd0);
        check("x0_wb_stall", 32'(wb_stall), 32'd0);
        next_cycle();
        wb_we = 0;
        dbg_req = 1; dbg_addr = 0; dbg_data = 32'h55;
        @(negedge clk);
        check("x0_dbg_we", 32'(rf_we), 32'd0);
        check("x0_dbg_ack", 32'(dbg_ack), 32'd1);
        next_cycle();
        dbg_req = 0;
        check("x0", rf_mem[0], 32'd0);

        // Reset into INIT, then reset again at idx 17
        rst = 0;
        next_cycle();
        rst = 1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("clr1_a3", 32'(rf_a3), 32'(i));
            next_cycle();
        end
        rst = 0;
        dbg_req = 1; dbg_addr = 3; dbg_data = 32'h33;
        @(negedge clk);
        check("mid_we", 32'(rf_we), 32'd0);
        check("mid_ack", 32'(dbg_ack), 32'd0);
        check("mid_stall", 32'(wb_stall), 32'd1);
        check("mid_busy", 32'(init_busy), 32'd1);
        next_cycle();
        rst = 1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("clr2_a3", 32'(rf_a3), 32'(i));
            check("clr2_ack", 32'(dbg_ack), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("re_busy", 32'(init_busy), 32'd0);
        check("re_ack", 32'(dbg_ack), 32'd1);
        check("re_a3", 32'(rf_a3), 32'd3);
        next_cycle();
        dbg_req = 0;
        check("x3", rf_mem[3], 32'h33);
        check("x9_recleared", rf_mem[9], 32'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Owns the single write port (A3/WD3/WE3) of the 32x32 RV32I register file.
- After reset, a sequencer clears all 32 registers to zero.
- In run mode, it arbitrates between the pipeline writeback stage (priority requester) and a debug write port (req/ack handshake, low priority with anti-starvation).
- Drives a stall to the pipeline while it holds the port.

Parameters:
- INIT_CLEAR, 1: 1 = clear x0..x31 after reset; 0 = enter RUN directly.
- MAX_WAIT, 4: cycles debug may be denied before it is forcibly granted. Legal range 1..15.
- NREG, 32: register count. Fixed at 32; address width 5.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- wb_we  in  1  writeback write request
- wb_addr  in  5  writeback destination register
- wb_data  in  32  writeback data
- dbg_req  in  1  debug write request; held until dbg_ack
- dbg_addr  in  5  debug destination register
- dbg_data  in  32  debug data
- dbg_ack  out  1  debug write accepted this cycle
- wb_stall  out  1  pipeline must hold its WB stage this cycle
- init_busy  out  1  clear sequence in progress
- rf_we  out  1  to register file WE3
- rf_a3  out  5  to register file A3
- rf_wd3  out  32  to register file WD3

Behaviour:
- State register: INIT or RUN. Also idx[4:0] (clear pointer) and wait_cnt[3:0]. All update only on posedge clk.
- While rst==0 at an edge: state<=INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0), idx<=0, wait_cnt<=0.
- Outputs while rst==0 (combinational override):
  - rf_we=0, rf_a3=0, rf_wd3=0, dbg_ack=0.
  - wb_stall=1, init_busy=INIT_CLEAR.
- rf_*, dbg_ack and wb_stall are combinational from the registered state plus the current inputs. A write takes effect at the same edge that ends the grant cycle (zero added latency).
- INIT:
  - rf_we=1, rf_a3=idx, rf_wd3=0; init_busy=1, wb_stall=1, dbg_ack=0.
  - idx increments each cycle. After idx==31 is written, state<=RUN.
  - Total: exactly 32 cycles. wb and dbg inputs are ignored.
- RUN grant priority:
  - Starvation: dbg_req && wb_we && wait_cnt==MAX_WAIT → grant debug, wb_stall=1, dbg_ack=1.
  - Else wb_we → grant writeback, wb_stall=0.
  - Else dbg_req → grant debug, dbg_ack=1.
  - Else idle: rf_we=0, rf_a3=0, rf_wd3=0.
- wait_cnt:
  - Increments when dbg_req=1 and debug is not granted, saturating at MAX_WAIT.
  - Clears to 0 on a debug grant or when dbg_req=0.
- x0 rule in RUN:
  - A granted write with address 0 drives rf_we=0.
  - The grant is still consumed: dbg_ack=1 for debug. Writeback to x0 is silently dropped.
- Handshake:
  - dbg_ack is a one-cycle pulse per accepted write.
  - The requester may keep dbg_req high the next cycle for a new write; each ack consumes one write.
  - dbg_addr and dbg_data must be stable while dbg_req=1 and unacked.
- wb_stall=1 means the pipeline holds wb_we/addr/data unchanged into the next cycle. The held write is granted then, because wait_cnt has cleared.
- Reset mid-INIT or mid-RUN restarts the sequence from idx=0. Pending debug is not acked.
- The read ports are untouched. Read/write same-cycle bypass is not this block's concern.

Decomposition:
- Shared package rf_pkg:
  - REG_AW=5, XLEN=32, REG_ZERO=5'd0.
  - State encoding constants ST_INIT=1'b0, ST_RUN=1'b1.
- One natural sub-module: rf_clear_seq (idx counter + INIT→RUN done flag).
- Arbitration and wait counter stay in the top.

Test Plan:
- Reset release, INIT_CLEAR=1 → 32 cycles with rf_we=1, rf_a3=0..31, rf_wd3=0, init_busy=1. Cycle 33: init_busy=0, state RUN. Readback of x2 (preloaded 3) returns 0.
- RUN, wb_we=1, wb_addr=9, wb_data=0x20, no dbg → rf_we=1, rf_a3=9, rf_wd3=0x20 same cycle, wb_stall=0. x9 reads 0x20 after the edge.
- dbg_req=1, addr=6, data=0x40 with wb_we=0 → dbg_ack=1 same cycle. x6=0x40. wait_cnt stays 0.
- dbg_req held with wb_we=1 continuously, MAX_WAIT=4 → wb granted 4 cycles. Cycle 5: dbg_ack=1, wb_stall=1, rf_a3=dbg_addr. Cycle 6: held wb write granted, wait_cnt=0.
- wb write to x0 with data 0xFFFFFFFF, then dbg write to x0 → rf_we=0 both cycles, dbg_ack=1. x0 reads 0.
- rst=0 asserted at INIT idx=17 for 1 cycle → outputs forced idle. After release, clear restarts at idx=0 and runs 32 cycles.
